// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded ops, forwards MEM/WB results into the
// ALU operands, stalls on load-use hazards and supports valid/ready flow control with flush.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      ID_ALUCtl_i,
  input  logic [RA_W-1:0] ID_Rs1_i,
  input  logic [RA_W-1:0] ID_Rs2_i,
  input  logic [RA_W-1:0] ID_Rd_i,
  input  logic [XLEN-1:0] ID_Rs1Data_i,
  input  logic [XLEN-1:0] ID_Rs2Data_i,
  input  logic [XLEN-1:0] ID_Imm_i,
  input  logic [XLEN-1:0] ID_PC_i,
  input  logic            ID_ALUSrc_i,
  input  logic            ID_UsePC_i,
  input  logic            ID_RegWrite_i,
  input  logic            ID_MemRead_i,
  input  logic            ID_MemWrite_i,
  input  logic            MEM_RegWrite_i,
  input  logic [RA_W-1:0] MEM_Rd_i,
  input  logic [XLEN-1:0] MEM_Res_i,
  input  logic            WB_RegWrite_i,
  input  logic [RA_W-1:0] WB_Rd_i,
  input  logic [XLEN-1:0] WB_Res_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [3:0]      ALUCtl_o,
  output logic [XLEN-1:0] Op1_o,
  output logic [XLEN-1:0] Op2_o,
  output logic [XLEN-1:0] StoreData_o,
  output logic [RA_W-1:0] Rd_o,
  output logic            RegWrite_o,
  output logic            MemRead_o,
  output logic            MemWrite_o
);

  logic            valid_q,     valid_d;
  logic [3:0]      alu_ctl_q,   alu_ctl_d;
  logic [RA_W-1:0] rs1_q,       rs1_d;
  logic [RA_W-1:0] rs2_q,       rs2_d;
  logic [RA_W-1:0] rd_q,        rd_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic            alu_src_q,   alu_src_d;
  logic            use_pc_q,    use_pc_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q,  mem_read_d;
  logic            mem_write_q, mem_write_d;

  logic            hazard;
  logic            advance;
  logic            accept;
  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  always_comb begin
    hazard = in_valid_i & valid_q & mem_read_q & (rd_q != '0) &
             (((rd_q == ID_Rs1_i) & ~ID_UsePC_i) | (rd_q == ID_Rs2_i));
    advance    = ~valid_q | out_ready_i;
    in_ready_o = advance & ~hazard;
    accept     = in_valid_i & in_ready_o & ~flush_i;
    wb_hit_rs1 = WB_RegWrite_i & (WB_Rd_i != '0) & (WB_Rd_i == ID_Rs1_i);
    wb_hit_rs2 = WB_RegWrite_i & (WB_Rd_i != '0) & (WB_Rd_i == ID_Rs2_i);
  end

  // MEM beats WB beats captured data; x0 always reads its captured value.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
    if (FWD_EN != 0) begin
      if (rs1_q != '0) begin
        if (MEM_RegWrite_i && (MEM_Rd_i == rs1_q))     fwd_rs1 = MEM_Res_i;
        else if (WB_RegWrite_i && (WB_Rd_i == rs1_q))  fwd_rs1 = WB_Res_i;
      end
      if (rs2_q != '0) begin
        if (MEM_RegWrite_i && (MEM_Rd_i == rs2_q))     fwd_rs2 = MEM_Res_i;
        else if (WB_RegWrite_i && (WB_Rd_i == rs2_q))  fwd_rs2 = WB_Res_i;
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    alu_ctl_d   = alu_ctl_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    alu_src_d   = alu_src_q;
    use_pc_d    = use_pc_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (accept) begin
      valid_d     = 1'b1;
      alu_ctl_d   = ID_ALUCtl_i;
      rs1_d       = ID_Rs1_i;
      rs2_d       = ID_Rs2_i;
      rd_d        = ID_Rd_i;
      rs1_data_d  = wb_hit_rs1 ? WB_Res_i : ID_Rs1Data_i;
      rs2_data_d  = wb_hit_rs2 ? WB_Res_i : ID_Rs2Data_i;
      imm_d       = ID_Imm_i;
      pc_d        = ID_PC_i;
      alu_src_d   = ID_ALUSrc_i;
      use_pc_d    = ID_UsePC_i;
      reg_write_d = ID_RegWrite_i;
      mem_read_d  = ID_MemRead_i;
      mem_write_d = ID_MemWrite_i;
    end else if (advance || flush_i) begin
      valid_d     = 1'b0;
      alu_ctl_d   = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      pc_d        = '0;
      alu_src_d   = 1'b0;
      use_pc_d    = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      // Held op: latch forwarded values so a retiring WB result is not lost.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q     <= 1'b0;
      alu_ctl_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      alu_src_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_ctl_q   <= alu_ctl_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      alu_src_q   <= alu_src_d;
      use_pc_q    <= use_pc_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  always_comb begin
    out_valid_o = valid_q;
    ALUCtl_o    = alu_ctl_q;
    Rd_o        = rd_q;
    RegWrite_o  = valid_q & reg_write_q;
    MemRead_o   = valid_q & mem_read_q;
    MemWrite_o  = valid_q & mem_write_q;
    Op1_o       = use_pc_q  ? pc_q  : fwd_rs1;
    Op2_o       = alu_src_q ? imm_q : fwd_rs2;
    StoreData_o = fwd_rs2;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of decoded ops checked through a scoreboard queue,
// then directed sequences for forwarding, load-use stall, hold refresh, flush and async reset.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst_n_i, flush_i, in_valid_i, in_ready_o;
  logic [3:0]      ID_ALUCtl_i;
  logic [RA_W-1:0] ID_Rs1_i, ID_Rs2_i, ID_Rd_i;
  logic [XLEN-1:0] ID_Rs1Data_i, ID_Rs2Data_i, ID_Imm_i, ID_PC_i;
  logic            ID_ALUSrc_i, ID_UsePC_i, ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i;
  logic            MEM_RegWrite_i, WB_RegWrite_i;
  logic [RA_W-1:0] MEM_Rd_i, WB_Rd_i;
  logic [XLEN-1:0] MEM_Res_i, WB_Res_i;
  logic            out_valid_o, out_ready_i;
  logic [3:0]      ALUCtl_o;
  logic [XLEN-1:0] Op1_o, Op2_o, StoreData_o;
  logic [RA_W-1:0] Rd_o;
  logic            RegWrite_o, MemRead_o, MemWrite_o;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ID_ALUCtl_i(ID_ALUCtl_i), .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i), .ID_Rd_i(ID_Rd_i),
    .ID_Rs1Data_i(ID_Rs1Data_i), .ID_Rs2Data_i(ID_Rs2Data_i), .ID_Imm_i(ID_Imm_i),
    .ID_PC_i(ID_PC_i), .ID_ALUSrc_i(ID_ALUSrc_i), .ID_UsePC_i(ID_UsePC_i),
    .ID_RegWrite_i(ID_RegWrite_i), .ID_MemRead_i(ID_MemRead_i), .ID_MemWrite_i(ID_MemWrite_i),
    .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_Rd_i(MEM_Rd_i), .MEM_Res_i(MEM_Res_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_Rd_i(WB_Rd_i), .WB_Res_i(WB_Res_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ALUCtl_o(ALUCtl_o), .Op1_o(Op1_o), .Op2_o(Op2_o), .StoreData_o(StoreData_o),
    .Rd_o(Rd_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o)
  );

  typedef struct {
    logic [3:0]      alu;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] d1, d2, imm, pc;
    logic            src, upc, rw, mr, mw;
    logic [XLEN-1:0] e_op1, e_op2, e_st;
  } vec_t;

  typedef struct {
    logic [3:0]      alu;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] op1, op2, st;
    logic            rw, mr, mw;
  } exp_t;

  localparam int NV = 7;
  vec_t tbl [NV];
  exp_t sb [$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] alu, input logic [RA_W-1:0] rs1, rs2, rd,
                               input logic [XLEN-1:0] d1, d2, imm, pc,
                               input logic src, upc, rw, mr, mw);
    vec_t v;
    v = '{alu, rs1, rs2, rd, d1, d2, imm, pc, src, upc, rw, mr, mw, '0, '0, '0};
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    in_valid_i    = 1'b1;
    ID_ALUCtl_i   = v.alu;
    ID_Rs1_i      = v.rs1;
    ID_Rs2_i      = v.rs2;
    ID_Rd_i       = v.rd;
    ID_Rs1Data_i  = v.d1;
    ID_Rs2Data_i  = v.d2;
    ID_Imm_i      = v.imm;
    ID_PC_i       = v.pc;
    ID_ALUSrc_i   = v.src;
    ID_UsePC_i    = v.upc;
    ID_RegWrite_i = v.rw;
    ID_MemRead_i  = v.mr;
    ID_MemWrite_i = v.mw;
  endtask

  task automatic idle_id();
    drive_vec(mkv(4'h0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    in_valid_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'h0, 5'd0,  5'd0,  5'd1,  32'h0,        32'h0,        32'h5,        32'h100,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h5,        32'h0};
    tbl[1] = '{4'h8, 5'd2,  5'd3,  5'd4,  32'h30,       32'h10,       32'h7,        32'h104,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h30,       32'h10,       32'h10};
    tbl[2] = '{4'h0, 5'd0,  5'd0,  5'd6,  32'h0,        32'h0,        32'h1000,     32'h108,
               1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h108,      32'h1000,     32'h0};
    tbl[3] = '{4'h0, 5'd8,  5'd9,  5'd0,  32'h2000,     32'hCAFEBABE, 32'hFFFFFFFC, 32'h10C,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000,     32'hFFFFFFFC, 32'hCAFEBABE};
    tbl[4] = '{4'h0, 5'd8,  5'd0,  5'd0,  32'h2000,     32'h0,        32'h4,        32'h110,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000,     32'h4,        32'h0};
    tbl[5] = '{4'h4, 5'd0,  5'd0,  5'd10, 32'h0,        32'h0,        32'h0,        32'h114,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};
    tbl[6] = '{4'h7, 5'd12, 5'd13, 5'd31, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0,        32'h118,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0F0F0F0F};

    rst_n_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    MEM_RegWrite_i = 1'b0; MEM_Rd_i = '0; MEM_Res_i = '0;
    WB_RegWrite_i  = 1'b0; WB_Rd_i  = '0; WB_Res_i  = '0;
    idle_id();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",    32'(out_valid_o), 32'h0);
    chk("rst_regwrite", 32'(RegWrite_o),  32'h0);
    chk("rst_in_ready", 32'(in_ready_o),  32'h1);
    chk("rst_op1",      Op1_o,            32'h0);
    chk("rst_op2",      Op2_o,            32'h0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;

    // Back-to-back table ops through the scoreboard
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive_vec(tbl[i]); else idle_id();
      @(negedge clk);
      if (out_valid_o) begin
        if (sb.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
        else begin
          e = sb.pop_front();
          chk("tbl_alu",   32'(ALUCtl_o),    32'(e.alu));
          chk("tbl_op1",   Op1_o,            e.op1);
          chk("tbl_op2",   Op2_o,            e.op2);
          chk("tbl_store", StoreData_o,      e.st);
          chk("tbl_rd",    32'(Rd_o),        32'(e.rd));
          chk("tbl_rw",    32'(RegWrite_o),  32'(e.rw));
          chk("tbl_mr",    32'(MemRead_o),   32'(e.mr));
          chk("tbl_mw",    32'(MemWrite_o),  32'(e.mw));
        end
      end
      if (i < NV) begin
        chk("tbl_in_ready", 32'(in_ready_o), 32'h1);
        if (in_ready_o)
          sb.push_back('{tbl[i].alu, tbl[i].rd, tbl[i].e_op1, tbl[i].e_op2, tbl[i].e_st,
                         tbl[i].rw, tbl[i].mr, tbl[i].mw});
      end
      tick();
    end
    @(negedge clk);
    chk("drain_valid", 32'(out_valid_o), 32'h0);
    chk("drain_rw",    32'(RegWrite_o),  32'h0);
    chk("sb_empty",    32'(sb.size()),   32'h0);
    tick();

    // MEM over WB priority, then WB, then hold refresh of the WB value
    drive_vec(mkv(4'h8, 5'd3, 5'd4, 5'd2, 32'h99, 32'h5, 32'h0, 32'h200,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    MEM_RegWrite_i = 1'b1; MEM_Rd_i = 5'd3; MEM_Res_i = 32'h10;
    WB_RegWrite_i  = 1'b1; WB_Rd_i  = 5'd3; WB_Res_i  = 32'h20;
    @(negedge clk);
    chk("fwd_mem_op1", Op1_o,          32'h10);
    chk("fwd_op2",     Op2_o,          32'h5);
    chk("fwd_alu",     32'(ALUCtl_o),  32'h8);
    MEM_RegWrite_i = 1'b0;
    #1;
    chk("fwd_wb_op1",  Op1_o,          32'h20);
    tick();
    WB_RegWrite_i = 1'b0;
    @(negedge clk);
    chk("refresh_op1", Op1_o,          32'h20);
    chk("refresh_rd",  32'(Rd_o),      32'h2);
    out_ready_i = 1'b1;
    tick();

    // x0 not forwarded; WB value bypassed into capture
    drive_vec(mkv(4'h0, 5'd0, 5'd9, 5'd13, 32'h0, 32'h1, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    WB_RegWrite_i = 1'b1; WB_Rd_i = 5'd9; WB_Res_i = 32'h77;
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0; WB_RegWrite_i = 1'b0;
    MEM_RegWrite_i = 1'b1; MEM_Rd_i = 5'd0; MEM_Res_i = 32'h55;
    @(negedge clk);
    chk("x0_op1",     Op1_o,       32'h0);
    chk("bypass_op2", Op2_o,       32'h77);
    chk("bypass_st",  StoreData_o, 32'h77);
    MEM_RegWrite_i = 1'b0; out_ready_i = 1'b1;
    tick();

    // Load-use: one-cycle stall, bubble, then WB forwarding of the load data
    drive_vec(mkv(4'h0, 5'd1, 5'd0, 5'd5, 32'h3000, 32'h0, 32'h0, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    tick();
    in_valid_i = 1'b0; ID_Rs1_i = 5'd0; ID_Rs2_i = 5'd5; ID_UsePC_i = 1'b0;
    @(negedge clk);
    chk("hz_gated", 32'(in_ready_o), 32'h1);
    in_valid_i = 1'b1;
    #1 chk("hz_rs2", 32'(in_ready_o), 32'h0);
    ID_Rs2_i = 5'd0; ID_Rs1_i = 5'd5; ID_UsePC_i = 1'b1;
    #1 chk("hz_usepc", 32'(in_ready_o), 32'h1);
    drive_vec(mkv(4'h0, 5'd2, 5'd5, 5'd6, 32'h7, 32'h1, 32'h0, 32'h120,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    #1 chk("hz_stall", 32'(in_ready_o), 32'h0);
    chk("hz_load_mr", 32'(MemRead_o), 32'h1);
    tick();
    MEM_RegWrite_i = 1'b1; MEM_Rd_i = 5'd5; MEM_Res_i = 32'h3000;
    @(negedge clk);
    chk("bubble_valid", 32'(out_valid_o), 32'h0);
    chk("bubble_mr",    32'(MemRead_o),   32'h0);
    chk("bubble_ready", 32'(in_ready_o),  32'h1);
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0; MEM_RegWrite_i = 1'b0;
    WB_RegWrite_i = 1'b1; WB_Rd_i = 5'd5; WB_Res_i = 32'hDEAD;
    @(negedge clk);
    chk("lu_valid", 32'(out_valid_o), 32'h1);
    chk("lu_op2",   Op2_o,            32'hDEAD);
    chk("lu_op1",   Op1_o,            32'h7);
    chk("lu_rd",    32'(Rd_o),        32'h6);
    WB_RegWrite_i = 1'b0; out_ready_i = 1'b1;
    tick();

    // Three-cycle hold while WB writes x7 for a single cycle
    drive_vec(mkv(4'h6, 5'd7, 5'd8, 5'd14, 32'h11, 32'h22, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    WB_RegWrite_i = 1'b1; WB_Rd_i = 5'd7; WB_Res_i = 32'h44;
    @(negedge clk);
    chk("hold_wb_op1", Op1_o, 32'h44);
    tick();
    WB_RegWrite_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("hold_op1",   Op1_o,            32'h44);
      chk("hold_op2",   Op2_o,            32'h22);
      chk("hold_rd",    32'(Rd_o),        32'he);
      chk("hold_alu",   32'(ALUCtl_o),    32'h6);
      chk("hold_valid", 32'(out_valid_o), 32'h1);
      tick();
    end
    out_ready_i = 1'b1;
    tick();

    // Flush beats hold, and beats accept into an empty stage
    drive_vec(mkv(4'h0, 5'd8, 5'd9, 5'd0, 32'h2000, 32'hAB, 32'h8, 32'h0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    chk("st_held_mw", 32'(MemWrite_o), 32'h1);
    tick();
    drive_vec(mkv(4'h0, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ready_held", 32'(in_ready_o), 32'h0);
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(out_valid_o), 32'h0);
    chk("flush_mw",    32'(MemWrite_o),  32'h0);
    chk("flush_rd",    32'(Rd_o),        32'h0);
    tick();
    @(negedge clk);
    chk("flush_not_taken", 32'(out_valid_o), 32'h0);
    tick();
    out_ready_i = 1'b1;
    drive_vec(mkv(4'h0, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_empty_ready", 32'(in_ready_o), 32'h1);
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", 32'(out_valid_o), 32'h0);
    chk("flush_empty_rw",    32'(RegWrite_o),  32'h0);
    tick();

    // Asynchronous reset drops a held op immediately
    drive_vec(mkv(4'h0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    chk("pre_arst_valid", 32'(out_valid_o), 32'h1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'h0);
    chk("arst_rw",    32'(RegWrite_o),  32'h0);
    chk("arst_rd",    32'(Rd_o),        32'h0);
    tick();
    rst_n_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
